pipe_stage_skid: RTL and testbench

- Parametrised next-generation pipeline register that replaces the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries an instruction word plus a packed control-signal bundle between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops an instruction.
- A synchronous flush empties the stage and substitutes a NOP, which supports branch/call squash.

---
 rtl/pipe_stage_skid.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
module pipe_stage_skid #(
  parameter int              IW        = 32,
  parameter int              CW        = 16,
  parameter logic [IW-1:0]   NOP_INSTR = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_instr,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_instr,
  output logic [CW-1:0]    out_ctrl,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [CW-1:0] ctrl;
  } entry_t;

  localparam entry_t NOP_ENTRY = {NOP_INSTR, {CW{1'b0}}};

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;

  state_t w_state_nxt;
  entry_t w_main_nxt;
  entry_t w_skid_nxt;
  entry_t w_in_entry;
  logic   w_in_fire;
  logic   w_out_fire;

  // Handshake outputs come from registered state only, so out_ready never reaches in_ready.
  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign out_instr  = out_valid ? r_main.instr : NOP_INSTR;
  assign out_ctrl   = out_valid ? r_main.ctrl  : '0;
  assign occupancy  = r_state;

  assign w_in_fire  = in_valid  & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_in_entry = {in_instr, in_ctrl};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = NOP_ENTRY;
      w_skid_nxt  = NOP_ENTRY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_main_nxt  = w_in_entry;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt  = w_in_entry;
          end else if (w_in_fire) begin
            w_state_nxt = FULL;
            w_skid_nxt  = w_in_entry;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset too, so the bubble contents are defined from time zero.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      r_state <= EMPTY;
      r_main  <= NOP_ENTRY;
      r_skid  <= NOP_ENTRY;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (!out_valid && out_ready && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (flush && (r_state != EMPTY) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model plus directed literal checks.
module tb_pipe_stage_skid;

  localparam int IW    = 32;
  localparam int CW    = 16;
  localparam int CNT_W = 4;
  localparam logic [IW-1:0] NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          R;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  int exp_stall, exp_bubble, exp_flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW+CW-1:0] q[$];
  int               m_n;
  bit               m_in_fire, m_out_fire;

  pipe_stage_skid #(.IW(IW), .CW(CW), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .Clk       (clk),
    .R         (R),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two entries.
  always @(posedge clk or negedge R) begin
    if (!R) begin
      q.delete();
`ifdef PIPE_STAGE_STATS_EN
      exp_stall = 0; exp_bubble = 0; exp_flush = 0;
`endif
    end else begin
      m_n        = q.size();
      m_in_fire  = in_valid && (m_n < 2);
      m_out_fire = (m_n != 0) && out_ready;
`ifdef PIPE_STAGE_STATS_EN
      if ((m_n != 0) && !out_ready && exp_stall  < (2**CNT_W - 1)) exp_stall++;
      if ((m_n == 0) &&  out_ready && exp_bubble < (2**CNT_W - 1)) exp_bubble++;
      if (flush && (m_n != 0)      && exp_flush  < (2**CNT_W - 1)) exp_flush++;
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire)  q.push_back({in_instr, in_ctrl});
      end
    end
  end

  // Every cycle: compare DUT outputs against the model.
  always @(negedge clk) begin
    check("m_occupancy", {62'd0, occupancy}, 64'(q.size()));
    check("m_in_ready",  {63'd0, in_ready},  64'(q.size() < 2));
    check("m_out_valid", {63'd0, out_valid}, 64'(q.size() != 0));
    check("m_out_instr", {32'd0, out_instr}, (q.size() != 0) ? 64'(q[0][IW+CW-1:CW]) : 64'(NOP));
    check("m_out_ctrl",  {48'd0, out_ctrl},  (q.size() != 0) ? 64'(q[0][CW-1:0]) : 64'd0);
`ifdef PIPE_STAGE_STATS_EN
    check("m_stall_cnt",  64'(stall_cnt),  64'(exp_stall));
    check("m_bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
    check("m_flush_cnt",  64'(flush_cnt),  64'(exp_flush));
`endif
  end

  initial begin
    R = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_ctrl = '0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'h0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'h0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    R = 1'b1;
    tick();
    check("rst_idle_occ", 64'(occupancy), 64'd0);

    // Stream 8 words with out_ready held high: one-cycle latency, one output per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h8200_0001 + 32'(i);
      in_ctrl  = 16'h00A0 + 16'(i);
      tick();
      check("stream_instr", 64'(out_instr), 64'(32'h8200_0001 + 32'(i)));
      check("stream_occ",   64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_occ", 64'(occupancy), 64'd0);

    // Fill the skid buffer under stall, then drain
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = 32'hC200_0000; in_ctrl = 16'h1111;
    tick();
    check("ab_occ1", 64'(occupancy), 64'd1);
    in_instr = 32'hC400_0004; in_ctrl = 16'h2222;
    tick();
    check("ab_occ2",     64'(occupancy), 64'd2);
    check("ab_in_ready", 64'(in_ready),  64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    check("ab_first", 64'(out_instr), 64'hC200_0000);
    tick();
    check("ab_second",   64'(out_instr), 64'hC400_0004);
    check("ab_occ_back", 64'(occupancy), 64'd1);
    tick();
    check("ab_empty", 64'(occupancy), 64'd0);

    // Flush while FULL with an instruction offered
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h1234_0001; in_ctrl = 16'h0F0F; tick();
    in_instr = 32'h1234_0002; tick();
    check("fl_full", 64'(occupancy), 64'd2);
    flush = 1'b1; in_instr = 32'h4000_0010;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ",       64'(occupancy), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_instr", 64'(out_instr), 64'h0);
    check("fl_out_ctrl",  64'(out_ctrl),  64'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_stays_empty", 64'(out_valid), 64'd0);
    end

    // Throughput from ONE: simultaneous in/out fire for 4 cycles
    in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h5000_0000; in_ctrl = 16'h0050;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_instr = 32'h5000_0000 + 32'(i);
      tick();
      check("tp_occ",   64'(occupancy), 64'd1);
      check("tp_instr", 64'(out_instr), 64'(32'h5000_0000 + 32'(i)));
    end

    // Reset asserted mid-transfer with the stage full
    out_ready = 1'b0; tick();
    check("mr_full", 64'(occupancy), 64'd2);
    R = 1'b0;
    #2;
    check("mr_occ",       64'(occupancy), 64'd0);
    check("mr_out_instr", 64'(out_instr), 64'h0);
    R = 1'b1; in_valid = 1'b0;
    tick();
    check("mr_idle", 64'(occupancy), 64'd0);

`ifdef PIPE_STAGE_STATS_EN
    // Long stall to saturate stall_cnt
    in_valid = 1'b1; in_instr = 32'h7777_0000; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("st_stall_sat", 64'(stall_cnt), 64'd15);
    R = 1'b0; #2;
    check("st_rst_stall",  64'(stall_cnt),  64'd0);
    check("st_rst_bubble", 64'(bubble_cnt), 64'd0);
    check("st_rst_flush",  64'(flush_cnt),  64'd0);
    R = 1'b1;
    tick();
`endif

    // Randomised traffic, holding offered data steady while stalled
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = $urandom;
        in_ctrl  = CW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("final_empty", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
